mem_req_arbiter: RTL and testbench

- Two-requester arbiter sharing one sparse_ram memory-model port between the data-side (port 0) and instruction-side (port 1) requesters.
- Arbitrates requests with round-robin priority.
- Records the requester ID of every issued request in an in-order tag FIFO.
- Routes each memory response back to the requester that issued it.
- Sits between the cache/fetch requesters and the memory model in the testbench memory path.

---
 rtl/mem_req_arbiter.sv | 162 ++++++++++++++++
 tb/tb_mem_req_arbiter.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_req_arbiter.sv
// Two-port arbiter sharing one in-order memory port, with a tag FIFO that routes responses home.
// Define MEM_ARB_FIXED_PRIO_EN to give port 0 fixed priority instead of round-robin.
module mem_req_arbiter #(
  parameter int BUS_WIDTH       = 64,
  parameter int ADDR_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic [1:0]                        req_valid_in,
  input  logic [1:0]                        req_write_in,
  input  logic [2*ADDR_WIDTH-1:0]           req_addr_in,
  input  logic [2*BUS_WIDTH-1:0]            req_data_in,
  output logic [1:0]                        req_ready_out,
  output logic [1:0]                        resp_valid_out,
  output logic [BUS_WIDTH-1:0]              resp_data_out,
  input  logic [1:0]                        resp_ready_in,
  output logic                              mem_req_valid_out,
  output logic                              mem_req_write_out,
  output logic [ADDR_WIDTH-1:0]             mem_req_addr_out,
  output logic [BUS_WIDTH-1:0]              mem_req_data_out,
  input  logic                              mem_req_ready_in,
  input  logic                              mem_resp_valid_in,
  input  logic [BUS_WIDTH-1:0]              mem_resp_data_in,
  output logic                              mem_resp_ready_out,
  output logic [$clog2(MAX_OUTSTANDING):0]  outstanding_out,
  output logic                              err_unexpected_resp_out
);

  localparam int PTR_W = $clog2(MAX_OUTSTANDING);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(MAX_OUTSTANDING);
  localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);

  typedef enum logic [1:0] {
    LOCK_NONE,
    LOCK_P0,
    LOCK_P1
  } lock_state_t;

  lock_state_t lock_state, lock_next;

  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             tag_mem [MAX_OUTSTANDING];

  logic full, empty;
  logic grant;
  logic req_go, issue, pop;
  logic head;
  logic resp_live;
  logic err;

  logic [ADDR_WIDTH-1:0] addr0, addr1;
  logic [BUS_WIDTH-1:0]  data0, data1;

  assign addr0 = req_addr_in[ADDR_WIDTH-1:0];
  assign addr1 = req_addr_in[2*ADDR_WIDTH-1:ADDR_WIDTH];
  assign data0 = req_data_in[BUS_WIDTH-1:0];
  assign data1 = req_data_in[2*BUS_WIDTH-1:BUS_WIDTH];

  assign full  = (count == FULL_COUNT);
  assign empty = (count == '0);

`ifndef MEM_ARB_FIXED_PRIO_EN
  logic rr_prio;

  always_ff @(posedge clock) begin
    if (reset) begin
      rr_prio <= 1'b0;
    end else if (issue) begin
      rr_prio <= ~grant;
    end
  end
`endif

  // A held lock always wins so the memory-side payload stays frozen across a stall.
  always_comb begin
    grant = 1'b0;
    if (lock_state == LOCK_P0) begin
      grant = 1'b0;
    end else if (lock_state == LOCK_P1) begin
      grant = 1'b1;
    end else if (req_valid_in == 2'b10) begin
      grant = 1'b1;
    end else if (req_valid_in == 2'b11) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
      grant = 1'b0;
`else
      grant = rr_prio;
`endif
    end
  end

  assign req_go            = (|req_valid_in) && !full;
  assign mem_req_valid_out = req_go && !reset;
  assign issue             = mem_req_valid_out && mem_req_ready_in;

  assign mem_req_write_out = req_write_in[grant];
  assign mem_req_addr_out  = grant ? addr1 : addr0;
  assign mem_req_data_out  = grant ? data1 : data0;
  assign req_ready_out     = issue ? (grant ? 2'b10 : 2'b01) : 2'b00;

  always_ff @(posedge clock) begin
    if (reset) begin
      lock_state <= LOCK_NONE;
    end else begin
      lock_state <= lock_next;
    end
  end

  always_comb begin
    lock_next = lock_state;
    if (issue) begin
      lock_next = LOCK_NONE;
    end else if (mem_req_valid_out) begin
      lock_next = grant ? LOCK_P1 : LOCK_P0;
    end
  end

  always_ff @(posedge clock) begin
    if (issue) begin
      tag_mem[wr_ptr] <= grant;
    end
  end

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (issue) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      count <= count + CNT_W'(issue) - CNT_W'(pop);
    end
  end

  assign head               = tag_mem[rd_ptr];
  assign resp_live          = mem_resp_valid_in && !empty && !reset;
  assign resp_valid_out     = head ? {resp_live, 1'b0} : {1'b0, resp_live};
  assign resp_data_out      = mem_resp_data_in;
  assign mem_resp_ready_out = !reset && !empty && resp_ready_in[head];
  assign pop                = mem_resp_valid_in && mem_resp_ready_out;

  always_ff @(posedge clock) begin
    if (reset) begin
      err <= 1'b0;
    end else if (mem_resp_valid_in && empty) begin
      err <= 1'b1;
    end
  end

  assign outstanding_out         = count;
  assign err_unexpected_resp_out = err;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Randomized bench for mem_req_arbiter against a queue-based reference of the arbitration rules.
// Honours MEM_ARB_FIXED_PRIO_EN in the same way as the design.
module tb_mem_req_arbiter;

  localparam int BUS_WIDTH       = 64;
  localparam int ADDR_WIDTH      = 32;
  localparam int MAX_OUTSTANDING = 4;
  localparam int CNT_W           = $clog2(MAX_OUTSTANDING) + 1;
`ifdef MEM_ARB_FIXED_PRIO_EN
  localparam bit FIXED_PRIO = 1'b1;
`else
  localparam bit FIXED_PRIO = 1'b0;
`endif

  logic                    clock = 1'b0;
  logic                    reset = 1'b1;
  logic [1:0]              req_valid_in = '0;
  logic [1:0]              req_write_in = '0;
  logic [2*ADDR_WIDTH-1:0] req_addr_in = '0;
  logic [2*BUS_WIDTH-1:0]  req_data_in = '0;
  logic [1:0]              req_ready_out;
  logic [1:0]              resp_valid_out;
  logic [BUS_WIDTH-1:0]    resp_data_out;
  logic [1:0]              resp_ready_in = '0;
  logic                    mem_req_valid_out;
  logic                    mem_req_write_out;
  logic [ADDR_WIDTH-1:0]   mem_req_addr_out;
  logic [BUS_WIDTH-1:0]    mem_req_data_out;
  logic                    mem_req_ready_in = 1'b0;
  logic                    mem_resp_valid_in = 1'b0;
  logic [BUS_WIDTH-1:0]    mem_resp_data_in = '0;
  logic                    mem_resp_ready_out;
  logic [CNT_W-1:0]        outstanding_out;
  logic                    err_unexpected_resp_out;

  always #5 clock = ~clock;

  mem_req_arbiter #(
    .BUS_WIDTH(BUS_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH),
    .MAX_OUTSTANDING(MAX_OUTSTANDING)
  ) dut (
    .clock(clock),
    .reset(reset),
    .req_valid_in(req_valid_in),
    .req_write_in(req_write_in),
    .req_addr_in(req_addr_in),
    .req_data_in(req_data_in),
    .req_ready_out(req_ready_out),
    .resp_valid_out(resp_valid_out),
    .resp_data_out(resp_data_out),
    .resp_ready_in(resp_ready_in),
    .mem_req_valid_out(mem_req_valid_out),
    .mem_req_write_out(mem_req_write_out),
    .mem_req_addr_out(mem_req_addr_out),
    .mem_req_data_out(mem_req_data_out),
    .mem_req_ready_in(mem_req_ready_in),
    .mem_resp_valid_in(mem_resp_valid_in),
    .mem_resp_data_in(mem_resp_data_in),
    .mem_resp_ready_out(mem_resp_ready_out),
    .outstanding_out(outstanding_out),
    .err_unexpected_resp_out(err_unexpected_resp_out)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  // Requesters: each holds a pending request until it is accepted.
  logic [1:0]            req_pend = '0;
  logic                  req_write [2];
  logic [ADDR_WIDTH-1:0] req_addr  [2];
  logic [BUS_WIDTH-1:0]  req_data  [2];

  // In-order memory: one queued response per issued request.
  logic [BUS_WIDTH-1:0] mem_q[$];
  bit                   resp_shown = 1'b0;
  logic [BUS_WIDTH-1:0] resp_drv = '0;

  // Reference view of the arbiter: who owns each outstanding response, who is preferred next, who is stalled.
  int tag_q[$];
  int prio_port  = 0;
  bit lock_valid = 1'b0;
  int lock_port  = 0;
  bit err_flag   = 1'b0;

  int unsigned p_req = 50, p_mem_ready = 50, p_resp = 50, p_resp_ready = 50;
  bit inject_bogus = 1'b0;

  bit exp_mem_valid, exp_issue, exp_pop, exp_empty;
  int exp_grant;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus();
    for (int i = 0; i < 2; i++) begin
      if (!req_pend[i] && $urandom_range(99) < p_req) begin
        req_pend[i]  = 1'b1;
        req_write[i] = 1'($urandom_range(1));
        req_addr[i]  = $urandom;
        req_data[i]  = {$urandom, $urandom};
      end
    end
    req_valid_in     = req_pend;
    req_write_in     = {req_write[1], req_write[0]};
    req_addr_in      = {req_addr[1], req_addr[0]};
    req_data_in      = {req_data[1], req_data[0]};
    mem_req_ready_in = ($urandom_range(99) < p_mem_ready);
    resp_ready_in[0] = ($urandom_range(99) < p_resp_ready);
    resp_ready_in[1] = ($urandom_range(99) < p_resp_ready);
    if (mem_q.size() != 0) begin
      if (!resp_shown && $urandom_range(99) < p_resp) resp_shown = 1'b1;
      resp_drv = resp_shown ? mem_q[0] : {$urandom, $urandom};
      mem_resp_valid_in = resp_shown;
    end else begin
      resp_shown = 1'b0;
      resp_drv = {$urandom, $urandom};
      mem_resp_valid_in = inject_bogus;
    end
    mem_resp_data_in = resp_drv;
  endtask

  task automatic checkCycle();
    bit full, exp_mresp_ready;
    int head;
    logic [1:0] exp_req_ready, exp_resp_valid;
    full      = (tag_q.size() == MAX_OUTSTANDING);
    exp_empty = (tag_q.size() == 0);
    if (lock_valid) exp_grant = lock_port;
    else if (req_valid_in == 2'b01) exp_grant = 0;
    else if (req_valid_in == 2'b10) exp_grant = 1;
    else exp_grant = FIXED_PRIO ? 0 : prio_port;
    exp_mem_valid   = (req_valid_in != 2'b00) && !full;
    exp_issue       = exp_mem_valid && mem_req_ready_in;
    exp_req_ready   = exp_issue ? 2'(1 << exp_grant) : 2'b00;
    head            = exp_empty ? 0 : tag_q[0];
    exp_resp_valid  = (mem_resp_valid_in && !exp_empty) ? 2'(1 << head) : 2'b00;
    exp_mresp_ready = !exp_empty && resp_ready_in[head];
    exp_pop         = mem_resp_valid_in && exp_mresp_ready;

    checkOutput("mem_req_valid", 64'(mem_req_valid_out), 64'(exp_mem_valid));
    checkOutput("req_ready", 64'(req_ready_out), 64'(exp_req_ready));
    if (exp_mem_valid) begin
      checkOutput("mem_req_write", 64'(mem_req_write_out), 64'(req_write[exp_grant]));
      checkOutput("mem_req_addr", 64'(mem_req_addr_out), 64'(req_addr[exp_grant]));
      checkOutput("mem_req_data", mem_req_data_out, req_data[exp_grant]);
    end
    checkOutput("resp_valid", 64'(resp_valid_out), 64'(exp_resp_valid));
    checkOutput("mem_resp_ready", 64'(mem_resp_ready_out), 64'(exp_mresp_ready));
    if (mem_resp_valid_in) checkOutput("resp_data", resp_data_out, resp_drv);
    checkOutput("outstanding", 64'(outstanding_out), 64'(tag_q.size()));
    checkOutput("err_unexpected", 64'(err_unexpected_resp_out), 64'(err_flag));
  endtask

  task automatic updateModel();
    if (mem_resp_valid_in && exp_empty) err_flag = 1'b1;
    if (exp_pop) begin
      void'(tag_q.pop_front());
      void'(mem_q.pop_front());
      resp_shown = 1'b0;
    end
    if (exp_issue) begin
      tag_q.push_back(exp_grant);
      mem_q.push_back({$urandom, $urandom});
      prio_port  = 1 - exp_grant;
      lock_valid = 1'b0;
      req_pend[exp_grant] = 1'b0;
    end else if (exp_mem_valid) begin
      lock_valid = 1'b1;
      lock_port  = exp_grant;
    end
  endtask

  task automatic runCycles(input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clock);
      applyStimulus();
      #1;
      checkCycle();
      @(posedge clock);
      updateModel();
    end
  endtask

  // Reset with every input asserted, so the forced-low outputs are visible.
  task automatic doReset();
    @(negedge clock);
    reset             = 1'b1;
    req_valid_in      = 2'b11;
    mem_req_ready_in  = 1'b1;
    mem_resp_valid_in = 1'b1;
    resp_ready_in     = 2'b11;
    #1;
    checkOutput("rst_mem_req_valid", 64'(mem_req_valid_out), 64'(0));
    checkOutput("rst_req_ready", 64'(req_ready_out), 64'(0));
    checkOutput("rst_resp_valid", 64'(resp_valid_out), 64'(0));
    checkOutput("rst_mem_resp_ready", 64'(mem_resp_ready_out), 64'(0));
    @(posedge clock);
    tag_q.delete();
    mem_q.delete();
    resp_shown = 1'b0;
    lock_valid = 1'b0;
    prio_port  = 0;
    err_flag   = 1'b0;
    req_pend   = '0;
    @(negedge clock);
    reset             = 1'b0;
    req_valid_in      = '0;
    mem_req_ready_in  = 1'b0;
    mem_resp_valid_in = 1'b0;
    resp_ready_in     = '0;
    #1;
    checkOutput("rst_outstanding", 64'(outstanding_out), 64'(0));
    checkOutput("rst_err", 64'(err_unexpected_resp_out), 64'(0));
  endtask

  task automatic setRates(input int unsigned rq, input int unsigned mr, input int unsigned rs, input int unsigned rr);
    p_req = rq;
    p_mem_ready = mr;
    p_resp = rs;
    p_resp_ready = rr;
  endtask

  initial begin
    doReset();

    setRates(60, 70, 50, 70);
    runCycles(300);

    // Requests outpace responses so the tag FIFO sits at full.
    setRates(90, 90, 15, 80);
    runCycles(150);

    // Long memory stalls exercise the lock; slow requesters block the response head.
    setRates(80, 25, 60, 30);
    runCycles(150);

    doReset();

    setRates(70, 60, 40, 60);
    runCycles(200);

    // Drain everything, then present a response with nothing outstanding.
    setRates(0, 100, 100, 100);
    runCycles(40);
    inject_bogus = 1'b1;
    runCycles(1);
    inject_bogus = 1'b0;
    runCycles(5);
    checkOutput("err_sticky", 64'(err_unexpected_resp_out), 64'(err_flag));

    doReset();
    setRates(60, 70, 50, 70);
    runCycles(100);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
